// File: rtl/speck_uart_host.sv
// Host-side sequencer for a UART-attached Speck engine: it sends a KEY/ENC/DEC
// command one byte at a time and assembles the response block from the controller.
module speck_uart_host #(
    parameter int TIMEOUT   = 100000,
    parameter int RSP_BYTES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_key,
    input  logic [63:0]  cmd_blk,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_busy,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rsp_valid,
    output logic [63:0]  rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic [2:0]   state_out
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(RSP_BYTES + 1);

    localparam logic [1:0] OP_KEY = 2'd0;
    localparam logic [1:0] OP_ENC = 2'd1;
    localparam logic [1:0] OP_DEC = 2'd2;
    localparam logic [1:0] OP_BAD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_TX_GAP  = 3'd2,
        S_TX_WAIT = 3'd3,
        S_RX_RSP  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_op;
    logic [135:0]   r_frame;
    logic [4:0]     r_idx;
    logic [TW-1:0]  r_tmo;
    logic [CW-1:0]  r_rx_cnt;
    logic [63:0]    r_rsp_data;
    logic           r_rsp_err;
    logic [7:0]     w_op_char;
    logic           w_last_byte;
    logic           w_rx_last;
    logic           w_tmo_fire;
    logic [7:0]     w_byte_we;

    always_comb begin
        w_op_char = 8'h44;
        case (cmd_op)
            OP_KEY:  w_op_char = 8'h4B;
            OP_ENC:  w_op_char = 8'h45;
            OP_DEC:  w_op_char = 8'h44;
            default: w_op_char = 8'h00;
        endcase
    end

    assign w_last_byte = (r_idx == ((r_op == OP_KEY) ? 5'd16 : 5'd8));
    assign w_rx_last   = (r_rx_cnt == CW'(RSP_BYTES - 1));
    // Fire on the edge that would take the counter to zero.
    assign w_tmo_fire  = (r_tmo <= TW'(1));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_we
            assign w_byte_we[gi] = (32'(r_rx_cnt) == gi);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (cmd_valid) w_state_next = (cmd_op == OP_BAD) ? S_DONE : S_SEND;
            S_SEND:    if (!tx_busy) w_state_next = S_TX_GAP;
            S_TX_GAP:  w_state_next = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!tx_busy) begin
                    if (!w_last_byte)        w_state_next = S_SEND;
                    else if (r_op == OP_KEY) w_state_next = S_DONE;
                    else                     w_state_next = S_RX_RSP;
                end
            end
            S_RX_RSP: begin
                if (rx_valid) begin
                    if (w_rx_last) w_state_next = S_DONE;
                end else if (w_tmo_fire) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_KEY;
            r_frame    <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_rx_cnt   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_idx      <= '0;
                        r_rx_cnt   <= '0;
                        r_rsp_data <= '0;
                        r_rsp_err  <= (cmd_op == OP_BAD);
                        if (cmd_op == OP_KEY) r_frame <= {w_op_char, cmd_key};
                        else                  r_frame <= {w_op_char, cmd_blk, 64'h0};
                    end
                end
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        r_idx   <= r_idx + 5'd1;
                        r_frame <= {r_frame[127:0], 8'h00};
                        if (w_last_byte && (r_op != OP_KEY)) r_tmo <= TW'(TIMEOUT);
                    end
                end
                S_RX_RSP: begin
                    if (rx_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            if (w_byte_we[i]) r_rsp_data[63 - 8*i -: 8] <= rx_data;
                        end
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                        r_tmo    <= TW'(TIMEOUT);
                    end else if (w_tmo_fire) begin
                        r_tmo     <= '0;
                        r_rsp_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign tx_valid  = (r_state == S_SEND) && !tx_busy;
    assign tx_data   = (r_state == S_SEND) ? r_frame[135:128] : 8'h00;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign state_out = r_state;
endmodule

// File: tb/tb_speck_uart_host.sv
// Self-checking bench for speck_uart_host: table vectors, randomized commands against
// a frame/response model, and hand-written busy-stall and mid-frame reset sequences.
module tb_speck_uart_host;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [127:0] cmd_key;
    logic [63:0]  cmd_blk;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_busy;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rsp_valid;
    logic [63:0]  rsp_data;
    logic         rsp_err;
    logic         busy;
    logic [2:0]   state_out;

    speck_uart_host #(.TIMEOUT(TMO), .RSP_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_blk(cmd_blk),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter stand-in: busy is tx_valid delayed one cycle, plus a forced hold.
    logic busy_dly = 1'b0;
    logic hold_busy = 1'b0;
    always @(posedge clk) busy_dly <= tx_valid;
    assign tx_busy = busy_dly | hold_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    int          rsp_cnt, rsp_cyc, acc_cyc, last_rx_cyc;
    int          spacing_bad, tx_in_hold, tx_after_rst;
    logic [63:0] rsp_d;
    logic        rsp_e;
    bit          held, completed;

    typedef struct {
        logic [1:0]   op;
        logic [127:0] key;
        logic [63:0]  blk;
        int           n_rx;
        logic [63:0]  rx_word;
        int           gap;
        int           exp_ntx;
        logic [63:0]  exp_d;
        logic         exp_e;
        int           exp_idle;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: opcode character, then key or block bytes, most significant first.
    function automatic void build_exp(input logic [1:0] op, input logic [127:0] key,
                                      input logic [63:0] blk);
        logic [7:0] ch;
        exp_q.delete();
        if (op == 2'd3) return;
        ch = (op == 2'd0) ? "K" : (op == 2'd1) ? "E" : "D";
        exp_q.push_back(ch);
        if (op == 2'd0) for (int i = 0; i < 16; i++) exp_q.push_back(8'(key >> (8 * (15 - i))));
        else            for (int i = 0; i < 8; i++)  exp_q.push_back(8'(blk >> (8 * (7 - i))));
    endfunction

    function automatic void model_rsp(input logic [1:0] op, input int n_rx, input logic [63:0] rx_word,
                                      output logic [63:0] d, output logic e);
        d = '0;
        e = (op == 2'd3);
        if (op == 2'd1 || op == 2'd2) begin
            for (int i = 0; i < n_rx; i++) d[63 - 8*i -: 8] = rx_word[63 - 8*i -: 8];
            e = (n_rx < 8);
        end
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [127:0] key, input logic [63:0] blk,
                           input int n_rx, input logic [63:0] rx_word, input int gap,
                           input int hold_at, input int rst_at);
        int rx_sent = 0, wait_ctr = 0, post = 0, hold_left = 0, rst_left = 0, last_tx = -100;
        bit stray = 0, rst_done = 0;
        tx_q.delete();
        rsp_cnt = 0; spacing_bad = 0; tx_in_hold = 0; tx_after_rst = 0;
        held = 0; completed = 0; rsp_cyc = 0; last_rx_cyc = 0;
        @(negedge clk);
        chk("accept_ready", cmd_ready, 1);
        cmd_op = op; cmd_key = key; cmd_blk = blk; cmd_valid = 1'b1;
        acc_cyc = cyc;
        for (int c = 0; c < 3000 && !completed; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                tx_q.push_back(tx_data);
                if (cyc - last_tx < 3) spacing_bad++;
                last_tx = cyc;
                if (hold_busy) tx_in_hold++;
                if (rst_done)  tx_after_rst++;
            end
            if (rsp_valid) begin
                rsp_cnt++; rsp_cyc = cyc; rsp_d = rsp_data; rsp_e = rsp_err;
            end
            cmd_valid = 1'b0;
            rx_valid  = 1'b0;
            if (c == 0) begin
                cmd_op  = 2'($urandom);
                cmd_key = {$urandom, $urandom, $urandom, $urandom};
                cmd_blk = {$urandom, $urandom};
            end
            if (!stray) begin
                rx_valid = 1'b1; rx_data = 8'hEE; stray = 1;
            end else if (state_out == 3'd4 && rx_sent < n_rx) begin
                if (wait_ctr == 0) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'(rx_word >> (56 - 8 * rx_sent));
                    last_rx_cyc = cyc;
                    rx_sent++;
                    wait_ctr = gap;
                end else begin
                    wait_ctr--;
                end
            end
            if (hold_at > 0 && !held && tx_q.size() == hold_at) begin
                hold_busy = 1'b1; hold_left = 100; held = 1;
            end else if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 50) begin cmd_valid = 1'b1; cmd_op = 2'd0; end
                if (hold_left == 0) hold_busy = 1'b0;
            end
            if (rst_at > 0 && !rst_done && tx_q.size() == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_tx_valid", tx_valid, 0);
                chk("rst_mid_state", state_out, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_ready", cmd_ready, 1);
                chk("rst_mid_rsp_valid", rsp_valid, 0);
                rst_done = 1; rst_left = 3;
            end else if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end
            if (rsp_cnt > 0 || (rst_done && rst_n)) begin
                post++;
                if ((rsp_cnt > 0 && post >= 3) || post >= 40) completed = 1;
            end
        end
        rx_valid = 1'b0; cmd_valid = 1'b0; hold_busy = 1'b0;
        $display("txn op=%0d ntx=%0d rsp_cnt=%0d rsp=%h err=%b", op, tx_q.size(), rsp_cnt, rsp_d, rsp_e);
    endtask

    task automatic verify(input string tag, input int exp_ntx, input logic [63:0] exp_d, input logic exp_e);
        chk({tag, "_done"}, completed, 1);
        chk({tag, "_ntx"}, tx_q.size(), exp_ntx);
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), tx_q[i], exp_q[i]);
        chk({tag, "_rsp_cnt"}, rsp_cnt, 1);
        chk({tag, "_rsp_data"}, rsp_d, exp_d);
        chk({tag, "_rsp_err"}, rsp_e, exp_e);
        chk({tag, "_spacing"}, spacing_bad, 0);
        chk({tag, "_rsp_held"}, rsp_data, exp_d);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   rop;
        logic [127:0] rkey;
        logic [63:0]  rblk, rrx, md;
        logic         me;
        int           rn, rgap;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_key = '0; cmd_blk = '0;
        rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_state", state_out, 0);
        rst_n = 1'b1;

        tbl[0] = '{2'd0, 128'h00010203_08090a0b_10111213_18191a1b, 64'h0, 0, 64'h0, 0,
                   17, 64'h0, 1'b0, -1};
        tbl[1] = '{2'd1, 128'h0, 64'h2d4375747465723b, 8, 64'h8CA56F8C48A56F8C, 2,
                   9, 64'h8CA56F8C48A56F8C, 1'b0, -1};
        tbl[2] = '{2'd2, 128'h0, 64'h0123456789abcdef, 3, 64'hAABBCC1122334455, 1,
                   9, 64'hAABBCC0000000000, 1'b1, TMO};
        tbl[3] = '{2'd3, 128'h5555, 64'h1234, 8, 64'hFFFFFFFFFFFFFFFF, 0,
                   0, 64'h0, 1'b1, -1};
        tbl[4] = '{2'd1, 128'h0, 64'hfedcba9876543210, 8, 64'h0102030405060708, TMO - 1,
                   9, 64'h0102030405060708, 1'b0, -1};
        tbl[5] = '{2'd2, 128'h0, 64'h0f0f0f0f0f0f0f0f, 8, 64'h1122334455667788, TMO,
                   9, 64'h1100000000000000, 1'b1, TMO};

        for (int i = 0; i < 6; i++) begin
            build_exp(tbl[i].op, tbl[i].key, tbl[i].blk);
            run_cmd(tbl[i].op, tbl[i].key, tbl[i].blk, tbl[i].n_rx, tbl[i].rx_word, tbl[i].gap, 0, 0);
            verify($sformatf("vec%0d", i), tbl[i].exp_ntx, tbl[i].exp_d, tbl[i].exp_e);
            if (tbl[i].exp_idle >= 0)
                chk($sformatf("vec%0d_idle", i), rsp_cyc - last_rx_cyc - 1, tbl[i].exp_idle);
            if (tbl[i].op == 2'd3)
                chk($sformatf("vec%0d_latency", i), (rsp_cyc - acc_cyc >= 1) && (rsp_cyc - acc_cyc <= 2), 1);
        end

        for (int r = 0; r < 12; r++) begin
            rop  = 2'($urandom_range(0, 3));
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rblk = {$urandom, $urandom};
            rrx  = {$urandom, $urandom};
            rn   = ($urandom % 2 == 0) ? 8 : $urandom_range(0, 8);
            rgap = $urandom_range(0, 20);
            build_exp(rop, rkey, rblk);
            model_rsp(rop, rn, rrx, md, me);
            run_cmd(rop, rkey, rblk, rn, rrx, rgap, 0, 0);
            verify($sformatf("rnd%0d", r), exp_q.size(), md, me);
        end

        rblk = {$urandom, $urandom};
        rrx  = {$urandom, $urandom};
        build_exp(2'd1, '0, rblk);
        run_cmd(2'd1, '0, rblk, 8, rrx, 0, 4, 0);
        verify("hold", 9, rrx, 1'b0);
        chk("hold_seen", held, 1);
        chk("hold_tx_during", tx_in_hold, 0);

        rkey = {$urandom, $urandom, $urandom, $urandom};
        build_exp(2'd0, rkey, '0);
        run_cmd(2'd0, rkey, '0, 0, '0, 0, 0, 5);
        chk("rstrun_done", completed, 1);
        chk("rstrun_ntx", tx_q.size(), 5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++)
            chk($sformatf("rstrun_tx%0d", i), tx_q[i], exp_q[i]);
        chk("rstrun_tx_after", tx_after_rst, 0);
        chk("rstrun_rsp_cnt", rsp_cnt, 0);

        rblk = {$urandom, $urandom};
        rrx  = {$urandom, $urandom};
        build_exp(2'd1, '0, rblk);
        run_cmd(2'd1, '0, rblk, 8, rrx, 1, 0, 0);
        verify("post_rst", 9, rrx, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
